// File: rtl/s_vector_ctrl_if.sv
// Signal bundle for the S coefficient-vector controller: load stream, fetch
// stream, status and the split read/write RAM port.
interface s_vector_ctrl_if #(
  parameter int word_size   = 16,
  parameter int num_vectors = 8,
  parameter int max_degree  = 10
);
  localparam int vw = $clog2(num_vectors);
  localparam int cw = $clog2(max_degree) + 1;

  logic                   ld_start;
  logic [vw-1:0]          ld_vector;
  logic [cw-1:0]          ld_degree;
  logic [word_size-1:0]   ld_data;
  logic                   ld_valid;
  logic                   ld_ready;
  logic                   ld_done;
  logic                   ld_err;

  logic                   fe_start;
  logic [vw-1:0]          fe_vector;
  logic [word_size-1:0]   fe_coef;
  logic                   fe_coef_valid;
  logic                   fe_last;
  logic [cw-1:0]          fe_degree;
  logic                   fe_done;
  logic                   fe_err;

  logic [num_vectors-1:0] vec_loaded;

  logic [word_size-1:0]   ram_data;
  logic [vw-1:0]          ram_wr_vector_addr;
  logic [cw-1:0]          ram_wr_coef_addr;
  logic                   ram_wr_en;
  logic [vw-1:0]          ram_rd_vector_addr;
  logic [cw-1:0]          ram_rd_coef_addr;
  logic                   ram_re_en;
  logic [word_size-1:0]   ram_q;
  logic                   ram_q_en;
  logic                   ram_wr_suc;

  modport slave (
    input  ld_start, ld_vector, ld_degree, ld_data, ld_valid,
    output ld_ready, ld_done, ld_err,
    input  fe_start, fe_vector,
    output fe_coef, fe_coef_valid, fe_last, fe_degree, fe_done, fe_err,
    output vec_loaded,
    output ram_data, ram_wr_vector_addr, ram_wr_coef_addr, ram_wr_en,
    output ram_rd_vector_addr, ram_rd_coef_addr, ram_re_en,
    input  ram_q, ram_q_en, ram_wr_suc
  );

  modport master (
    output ld_start, ld_vector, ld_degree, ld_data, ld_valid,
    input  ld_ready, ld_done, ld_err,
    output fe_start, fe_vector,
    input  fe_coef, fe_coef_valid, fe_last, fe_degree, fe_done, fe_err,
    input  vec_loaded,
    input  ram_data, ram_wr_vector_addr, ram_wr_coef_addr, ram_wr_en,
    input  ram_rd_vector_addr, ram_rd_coef_addr, ram_re_en,
    output ram_q, ram_q_en, ram_wr_suc
  );
endinterface

// File: rtl/s_vector_ctrl.sv
// S coefficient-vector RAM sequencer: streaming loader, highest-degree-first
// fetcher for Horner evaluation, and per-vector valid/degree bookkeeping.
//
// state   | meaning
// L_IDLE  | loader waiting for ld_start
// L_LOAD  | accepting beats k=0..d, one RAM write per beat
// L_FLUSH | waiting for the acknowledge of the final write
// L_DONE  | vector committed: valid flag and degree recorded
// F_IDLE  | fetcher waiting for fe_start
// F_ISSUE | one-cycle RAM read of coefficient k
// F_WAIT  | waiting for read data
// F_DONE  | last coefficient (k=0) on fe_coef
module s_vector_ctrl #(
  parameter int num_vectors = 8,
  parameter int max_degree  = 10
) (
  input logic            clk,
  input logic            rst,
  s_vector_ctrl_if.slave bus
);
  localparam int vw = $clog2(num_vectors);
  localparam int cw = $clog2(max_degree) + 1;

  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_FLUSH, L_DONE} l_state_t;
  typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_WAIT, F_DONE} f_state_t;

  l_state_t      l_state, l_state_nxt;
  f_state_t      f_state, f_state_nxt;

  logic [vw-1:0] l_vec;
  logic [cw-1:0] l_deg;
  logic [cw-1:0] l_k;
  logic [cw-1:0] l_acks;
  logic [vw-1:0] f_vec;
  logic [cw-1:0] f_k, f_k_nxt;
  logic [cw-1:0] deg_tbl [num_vectors];

  logic beat;
  logic ld_accept, ld_reject;
  logic fe_accept, fe_reject;
  logic coef_take;
  logic fe_busy_on_ld, ld_busy_on_fe, ld_claims_fe;
  logic ld_cmd_ok, fe_cmd_ok;

  // ---------------- loader ----------------
  always_comb begin
    l_state_nxt   = l_state;
    ld_accept     = 1'b0;
    ld_reject     = 1'b0;
    beat          = bus.ld_valid && bus.ld_ready;
    fe_busy_on_ld = (f_state != F_IDLE) && (f_vec == bus.ld_vector);
    ld_cmd_ok     = (int'(bus.ld_vector) < num_vectors) &&
                    (int'(bus.ld_degree) <= max_degree) && !fe_busy_on_ld;
    case (l_state)
      L_IDLE: begin
        if (bus.ld_start) begin
          if (ld_cmd_ok) begin
            ld_accept   = 1'b1;
            l_state_nxt = L_LOAD;
          end else begin
            ld_reject = 1'b1;
          end
        end
      end
      L_LOAD: begin
        if (beat && (l_k == l_deg)) l_state_nxt = L_FLUSH;
      end
      L_FLUSH: begin
        // earlier writes may still be acknowledging; only the (d+1)-th ack commits
        if (bus.ram_wr_suc && (l_acks == l_deg)) l_state_nxt = L_DONE;
      end
      L_DONE:  l_state_nxt = L_IDLE;
      default: l_state_nxt = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_state                <= L_IDLE;
      l_vec                  <= '0;
      l_deg                  <= '0;
      l_k                    <= '0;
      l_acks                 <= '0;
      bus.ld_ready           <= 1'b0;
      bus.ld_done            <= 1'b0;
      bus.ld_err             <= 1'b0;
      bus.ram_wr_en          <= 1'b0;
      bus.ram_wr_vector_addr <= '0;
      bus.ram_wr_coef_addr   <= '0;
      bus.ram_data           <= '0;
      bus.vec_loaded         <= '0;
      for (int i = 0; i < num_vectors; i++) deg_tbl[i] <= '0;
    end else begin
      l_state       <= l_state_nxt;
      bus.ld_ready  <= (l_state_nxt == L_LOAD);
      bus.ld_done   <= (l_state_nxt == L_DONE);
      bus.ld_err    <= ld_reject;
      bus.ram_wr_en <= beat;
      if (ld_accept) begin
        l_vec                          <= bus.ld_vector;
        l_deg                          <= bus.ld_degree;
        l_k                            <= '0;
        l_acks                         <= '0;
        bus.vec_loaded[bus.ld_vector]  <= 1'b0;
      end
      if (beat) begin
        bus.ram_wr_vector_addr <= l_vec;
        bus.ram_wr_coef_addr   <= l_k;
        bus.ram_data           <= bus.ld_data;
        l_k                    <= l_k + cw'(1);
      end
      if (bus.ram_wr_suc && ((l_state == L_LOAD) || (l_state == L_FLUSH)))
        l_acks <= l_acks + cw'(1);
      if ((l_state == L_FLUSH) && (l_state_nxt == L_DONE)) begin
        bus.vec_loaded[l_vec] <= 1'b1;
        deg_tbl[l_vec]        <= l_deg;
      end
    end
  end

  // ---------------- fetcher ----------------
  always_comb begin
    f_state_nxt   = f_state;
    f_k_nxt       = f_k;
    fe_accept     = 1'b0;
    fe_reject     = 1'b0;
    coef_take     = 1'b0;
    ld_busy_on_fe = (l_state != L_IDLE) && (l_vec == bus.fe_vector);
    // a load starting this very cycle on the same vector wins the collision
    ld_claims_fe  = ld_accept && (bus.ld_vector == bus.fe_vector);
    fe_cmd_ok     = (int'(bus.fe_vector) < num_vectors) && bus.vec_loaded[bus.fe_vector] &&
                    !ld_busy_on_fe && !ld_claims_fe;
    case (f_state)
      F_IDLE: begin
        if (bus.fe_start) begin
          if (fe_cmd_ok) begin
            fe_accept   = 1'b1;
            f_k_nxt     = deg_tbl[bus.fe_vector];
            f_state_nxt = F_ISSUE;
          end else begin
            fe_reject = 1'b1;
          end
        end
      end
      F_ISSUE: f_state_nxt = F_WAIT;
      F_WAIT: begin
        if (bus.ram_q_en) begin
          coef_take = 1'b1;
          if (f_k != '0) begin
            f_k_nxt     = f_k - cw'(1);
            f_state_nxt = F_ISSUE;
          end else begin
            f_state_nxt = F_DONE;
          end
        end
      end
      F_DONE:  f_state_nxt = F_IDLE;
      default: f_state_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_state                <= F_IDLE;
      f_vec                  <= '0;
      f_k                    <= '0;
      bus.fe_coef            <= '0;
      bus.fe_coef_valid      <= 1'b0;
      bus.fe_last            <= 1'b0;
      bus.fe_degree          <= '0;
      bus.fe_done            <= 1'b0;
      bus.fe_err             <= 1'b0;
      bus.ram_re_en          <= 1'b0;
      bus.ram_rd_vector_addr <= '0;
      bus.ram_rd_coef_addr   <= '0;
    end else begin
      f_state           <= f_state_nxt;
      f_k               <= f_k_nxt;
      bus.fe_err        <= fe_reject;
      bus.fe_done       <= (f_state_nxt == F_DONE);
      bus.fe_coef_valid <= coef_take;
      bus.fe_last       <= coef_take && (f_k == '0);
      bus.ram_re_en     <= (f_state_nxt == F_ISSUE);
      if (coef_take) bus.fe_coef <= bus.ram_q;
      if (fe_accept) begin
        f_vec         <= bus.fe_vector;
        bus.fe_degree <= deg_tbl[bus.fe_vector];
      end
      if (f_state_nxt == F_ISSUE) begin
        bus.ram_rd_vector_addr <= fe_accept ? bus.fe_vector : f_vec;
        bus.ram_rd_coef_addr   <= f_k_nxt;
      end
    end
  end
endmodule

// File: doc/s_vector_ctrl.md
Name: s_vector_ctrl

Overview:
Controller that sequences the S coefficient-vector RAM (num_vectors x (max_degree+1) words). It exposes a streaming load interface that writes one coefficient vector, and a fetch interface that reads a vector highest-degree-first for Horner evaluation. It also arbitrates the two interfaces and tracks per-vector valid and degree state.

Parameters:
word_size, 16, coefficient bit width
num_vectors, 8, number of coefficient vectors; VW = log2(num_vectors)
max_degree, 10, maximum polynomial degree; CW = log2(max_degree)+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ld_start  in  1  load command pulse
ld_vector  in  VW  target vector index
ld_degree  in  CW  degree d; d+1 coefficients follow
ld_data  in  word_size  coefficient beat, order k=0..d
ld_valid  in  1  ld_data valid
ld_ready  out  1  loader accepts beat
ld_done  out  1  one-cycle pulse: vector committed
ld_err  out  1  one-cycle pulse: load command rejected
fe_start  in  1  fetch command pulse
fe_vector  in  VW  vector to fetch
fe_coef  out  word_size  fetched coefficient
fe_coef_valid  out  1  fe_coef valid, one cycle per coefficient
fe_last  out  1  with fe_coef_valid: coefficient k=0
fe_degree  out  CW  degree of the vector being fetched, held until the next fetch
fe_done  out  1  one-cycle pulse: fetch complete
fe_err  out  1  one-cycle pulse: fetch command rejected
vec_loaded  out  num_vectors  per-vector valid flags
ram_data  out  word_size  RAM write data
ram_wr_vector_addr  out  VW  RAM write vector address
ram_wr_coef_addr  out  CW  RAM write coefficient address
ram_wr_en  out  1  RAM write enable
ram_rd_vector_addr  out  VW  RAM read vector address
ram_rd_coef_addr  out  CW  RAM read coefficient address
ram_re_en  out  1  RAM read enable, always a single-cycle pulse
ram_q  in  word_size  RAM read data
ram_q_en  in  1  RAM read-data valid
ram_wr_suc  in  1  RAM write acknowledge

Behaviour:
- Reset: every output is 0; vec_loaded and the degree table are cleared; both FSMs go to IDLE. Reset mid-operation aborts both FSMs. RAM contents are untouched but become unreachable because vec_loaded is cleared.
- All outputs are registered.
- Loader FSM states: L_IDLE, L_LOAD, L_FLUSH, L_DONE.
  - In L_IDLE, ld_start with ld_vector < num_vectors and ld_degree <= max_degree, and with ld_vector not the vector the fetcher is currently busy on:
    - capture vector v and degree d;
    - clear vec_loaded[v] in the next cycle;
    - set k = 0 and go to L_LOAD.
  - Any other ld_start pulses ld_err next cycle and the FSM stays in L_IDLE.
  - L_LOAD: ld_ready = 1. On ld_valid && ld_ready, the next cycle drives ram_wr_en = 1, ram_wr_vector_addr = v, ram_wr_coef_addr = k, ram_data = ld_data; then k increments. The beat with k == d leads to L_FLUSH and ld_ready drops in the same cycle that write issues.
  - L_FLUSH: wait for ram_wr_suc of the final write, then go to L_DONE.
  - L_DONE (one cycle): ld_done = 1, vec_loaded[v] = 1, degree table[v] = d; return to L_IDLE.
  - Timing: final beat accepted at cycle t -> ram_wr_en at t+1 -> ram_wr_suc at t+2 -> ld_done at t+3.
  - A ld_valid gap stalls the loader with no timeout.
- Fetch FSM states: F_IDLE, F_ISSUE, F_WAIT, F_DONE.
  - In F_IDLE, fe_start with vec_loaded[fe_vector] = 1 and the loader not in a non-idle state for the same vector: latch vector u, set k = degree table[u], update fe_degree, go to F_ISSUE.
  - Any other fe_start pulses fe_err.
  - F_ISSUE: one cycle with ram_re_en = 1, ram_rd_vector_addr = u, ram_rd_coef_addr = k; go to F_WAIT.
  - F_WAIT: on ram_q_en, the next cycle drives fe_coef = ram_q and fe_coef_valid = 1, with fe_last = 1 when k == 0. If k > 0, decrement k and return to F_ISSUE; otherwise go to F_DONE.
  - F_DONE: fe_done = 1 for one cycle, coincident with the fe_coef_valid/fe_last cycle; return to F_IDLE.
  - Throughput: one coefficient every 3 cycles. No downstream backpressure.
- Arbitration:
  - The RAM has separate read and write ports, so a load and a fetch run concurrently on different vectors.
  - If ld_start and fe_start arrive in the same cycle for the same vector, the load wins and the fetch gets fe_err.
  - ld_start for the vector currently being fetched gives ld_err.
  - Start pulses arriving while the owning FSM is not idle are ignored, with no error.
- Degree 0 load: exactly one beat. Degree 0 fetch: a single read with fe_last = 1.

Test Plan:
- Load v=3, d=2, beats 0x0001, 0x0002, 0x0003 -> three writes to (3,0), (3,1), (3,2); ld_done 3 cycles after the last beat; vec_loaded = 8'b0000_1000.
- Fetch v=3 after that load -> fe_coef sequence 0x0003, 0x0002, 0x0001 at 3-cycle spacing; fe_last and fe_done on the third; fe_degree = 2.
- Fetch v=5 (never loaded) -> fe_err one cycle later; no ram_re_en.
- ld_start with v=2, d=11 -> ld_err; no write. Simultaneous ld_start and fe_start both on v=3 -> load proceeds and fe_err pulses.
- Load v=1 (d=10) concurrently with fetch v=3 -> both complete with correct data. Then ld_start for v=3 during a fetch of v=3 -> ld_err.
- Assert rst mid-load of v=4 (after 2 beats) -> all outputs 0 and vec_loaded = 0; a subsequent fetch of v=3 -> fe_err.
